// File: rtl/pixel_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_stream_pkg
//  Description : Shared types and constants for the RGB pixel streamer.
//                Holds the default channel width, the border (pad) width,
//                the padded-side helper and the streamer FSM state type.
//                Optional feature macro: PIXEL_STREAMER_PAD_EN selects
//                whether padded_side() adds a zero border on each side.
//  Revision    : 1.0 - initial release
// ============================================================================
package pixel_stream_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int PAD_W              = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   // Side length of the emitted (possibly bordered) square frame.
   function automatic int padded_side(input int img_w);
`ifdef PIXEL_STREAMER_PAD_EN
      return img_w + 2 * PAD_W;
`else
      return img_w;
`endif
   endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid_fifo
//  Description : Two-entry skid FIFO. Absorbs the pixels already issued to
//                the frame RAM when the consumer stalls. The caller never
//                pushes into a full FIFO and never pops an empty one.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push_i/data_i   - write an entry
//                pop_i           - retire the head entry
//                count_o         - occupancy 0..2
//                head_o          - oldest entry (cleared value after reset)
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_fifo #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [1:0]       count_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] slot0_q;
   logic [WIDTH-1:0] slot1_q;
   logic             rd_ptr_q;
   logic             wr_ptr_q;
   logic [1:0]       count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot0_q  <= '0;
         slot1_q  <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            if (wr_ptr_q) slot1_q <= data_i;
            else          slot0_q <= data_i;
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign count_o = count_q;
   assign head_o  = rd_ptr_q ? slot1_q : slot0_q;

endmodule
`default_nettype wire

// File: rtl/rgb_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pixel_streamer
//  Description : Reads an unpadded RGB frame from a single-port frame RAM
//                (1-cycle read latency) and emits it in raster order on a
//                pixel/valid/ready stream, optionally wrapped in a zero
//                border. Issue -> in-flight -> 2-entry skid FIFO pipeline;
//                credit check keeps at most two pixels buffered/outstanding.
//  Macro       : PIXEL_STREAMER_PAD_EN - insert a one-pixel zero border.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start               - frame start, honoured in IDLE only
//                ready               - downstream accept
//                mem_rd_en/mem_addr  - frame RAM read strobe / raster index
//                mem_rdata_r/g/b     - RAM data, valid cycle after mem_rd_en
//                pixel_out_r/g/b     - stream pixel (FIFO head)
//                pixel_valid_r/g/b   - identical valid copies
//                busy                - high in STREAM/DRAIN
//                done                - one-cycle pulse after the last pixel
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_pixel_streamer
   import pixel_stream_pkg::*;
#(
   parameter int DATA_WIDTH = pixel_stream_pkg::DEFAULT_DATA_WIDTH,
   parameter int IMG_W      = 222,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  ready,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata_r,
   input  logic [DATA_WIDTH-1:0] mem_rdata_g,
   input  logic [DATA_WIDTH-1:0] mem_rdata_b,
   output logic [DATA_WIDTH-1:0] pixel_out_r,
   output logic [DATA_WIDTH-1:0] pixel_out_g,
   output logic [DATA_WIDTH-1:0] pixel_out_b,
   output logic                  pixel_valid_r,
   output logic                  pixel_valid_g,
   output logic                  pixel_valid_b,
   output logic                  busy,
   output logic                  done
);

   localparam int P_SIDE = padded_side(IMG_W);
   localparam int CW     = $clog2(P_SIDE + 1);
   localparam int FW     = 3 * DATA_WIDTH;

   state_t                state_q;
   logic [CW-1:0]         row_q, row_d;
   logic [CW-1:0]         col_q, col_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  infl_valid_q;
   logic                  infl_pad_q;
   logic                  done_q;

   logic [1:0]            fifo_count;
   logic [FW-1:0]         fifo_head;
   logic [FW-1:0]         fifo_wdata;
   logic                  pop;
   logic                  issue;
   logic                  interior;
   logic                  last_coord;
   logic                  drain_empty;
   logic [2:0]            occupancy;

   assign pop = (fifo_count != 2'd0) && ready;

   // Slots already committed after this cycle's pop; a new issue needs one free.
   assign occupancy = {1'b0, fifo_count} + {2'b00, infl_valid_q} - {2'b00, pop};
   assign issue     = (state_q == STREAM) && (occupancy < 3'd2);

`ifdef PIXEL_STREAMER_PAD_EN
   assign interior = (row_q >= CW'(PAD_W)) && (row_q <= CW'(IMG_W)) &&
                     (col_q >= CW'(PAD_W)) && (col_q <= CW'(IMG_W));
`else
   assign interior = 1'b1;
`endif

   assign last_coord  = (row_q == CW'(P_SIDE - 1)) && (col_q == CW'(P_SIDE - 1));
   // FIFO will be empty after this cycle and nothing is left to land.
   assign drain_empty = !infl_valid_q &&
                        ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

   // Raster counters; the linear address only advances on real reads.
   always_comb begin
      row_d  = row_q;
      col_d  = col_q;
      addr_d = addr_q;
      if ((state_q == IDLE) && start) begin
         row_d  = '0;
         col_d  = '0;
         addr_d = '0;
      end else if (issue) begin
         if (col_q == CW'(P_SIDE - 1)) begin
            col_d = '0;
            row_d = row_q + CW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
         if (interior) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         row_q        <= '0;
         col_q        <= '0;
         addr_q       <= '0;
         infl_valid_q <= 1'b0;
         infl_pad_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         row_q        <= row_d;
         col_q        <= col_d;
         addr_q       <= addr_d;
         infl_valid_q <= issue;
         infl_pad_q   <= issue && !interior;
         done_q       <= 1'b0;
         case (state_q)
            IDLE:    if (start) state_q <= STREAM;
            STREAM:  if (issue && last_coord) state_q <= DRAIN;
            DRAIN: begin
               if (drain_empty) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // RAM data is only looked at in the cycle its read lands.
   assign fifo_wdata = infl_pad_q ? '0 : {mem_rdata_r, mem_rdata_g, mem_rdata_b};

   stream_skid_fifo #(
      .WIDTH (FW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (infl_valid_q),
      .data_i  (fifo_wdata),
      .pop_i   (pop),
      .count_o (fifo_count),
      .head_o  (fifo_head)
   );

   assign mem_rd_en     = issue && interior;
   assign mem_addr      = addr_q;
   assign pixel_out_r   = fifo_head[3*DATA_WIDTH-1:2*DATA_WIDTH];
   assign pixel_out_g   = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
   assign pixel_out_b   = fifo_head[DATA_WIDTH-1:0];
   assign pixel_valid_r = (fifo_count != 2'd0);
   assign pixel_valid_g = (fifo_count != 2'd0);
   assign pixel_valid_b = (fifo_count != 2'd0);
   assign busy          = (state_q != IDLE);
   assign done          = done_q;

endmodule
`default_nettype wire
